// File: rtl/tsm_share_monomial_gen.sv
// Same-share monomial producer: takes one Boolean share per beat (share 0 first)
// and emits the 15 intra-nibble AND monomials of both nibbles of that share.
module tsm_share_monomial_gen #(
    parameter int NUM_SHARES = 2,
    parameter int IDX_W      = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_first,
    input  logic [7:0]       in_share,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [14:0]      out_mono_lo,
    output logic [14:0]      out_mono_hi,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             err
);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SHARES - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic [7:0]        share_q, share_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              last_q, last_d;
    logic              err_q, err_d;
    logic              accept;

    function automatic logic [14:0] mono4(input logic [3:0] x);
        mono4 = {&x,
                 x[1] & x[2] & x[3], x[0] & x[2] & x[3],
                 x[0] & x[1] & x[3], x[0] & x[1] & x[2],
                 x[2] & x[3], x[1] & x[3], x[1] & x[2],
                 x[0] & x[3], x[0] & x[2], x[0] & x[1],
                 x[3], x[2], x[1], x[0]};
    endfunction

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q && !out_ready;
        share_d = share_q;
        idx_d   = idx_q;
        last_d  = last_q;
        err_d   = 1'b0;

        if (clr) begin
            // Abort wins over everything; data is wiped so no stale share lingers.
            state_d = IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
            share_d = '0;
            idx_d   = '0;
            last_d  = 1'b0;
        end else if (accept) begin
            if (in_first) begin
                // A new byte always restarts at share 0, even if one was in progress.
                err_d   = (state_q == COLLECT);
                valid_d = 1'b1;
                share_d = in_share;
                idx_d   = '0;
                if (NUM_SHARES == 1) begin
                    last_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    last_d  = 1'b0;
                    cnt_d   = ONE_IDX;
                    state_d = COLLECT;
                end
            end else if (state_q == IDLE) begin
                err_d = 1'b1;
            end else begin
                valid_d = 1'b1;
                share_d = in_share;
                idx_d   = cnt_q;
                if (cnt_q == LAST_IDX) begin
                    last_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    last_d  = 1'b0;
                    cnt_d   = cnt_q + ONE_IDX;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            share_q <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            share_q <= share_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    // Monomials are formed only from the registered share, never from in_share.
    assign out_mono_lo = mono4(share_q[3:0]);
    assign out_mono_hi = mono4(share_q[7:4]);
    assign out_valid   = valid_q;
    assign out_idx     = idx_q;
    assign out_last    = last_q;
    assign err         = err_q;

endmodule
